// File: rtl/video_timing_pkg.sv
// Shared types, reset-default timing and config legality check for the raster generator.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package video_timing_pkg;

    // Config fields are sized for the widest axis any instance may use.
    // Narrower axes zero-extend into them.
    localparam int CFG_W = 16;

    localparam int H_VISIBLE_DEF    = 256;
    localparam int H_SYNC_START_DEF = 280;
    localparam int H_SYNC_END_DEF   = 305;
    localparam int H_TOTAL_DEF      = 341;
    localparam int V_VISIBLE_DEF    = 240;
    localparam int V_SYNC_START_DEF = 243;
    localparam int V_SYNC_END_DEF   = 246;
    localparam int V_TOTAL_DEF      = 262;

    typedef struct packed {
        logic [CFG_W-1:0] visible;
        logic [CFG_W-1:0] sync_start;
        logic [CFG_W-1:0] sync_end;
        logic [CFG_W-1:0] total;
    } axis_cfg_t;

    function automatic axis_cfg_t make_cfg(input int vis, input int ss, input int se, input int tot);
        axis_cfg_t c;
        c.visible    = CFG_W'(vis);
        c.sync_start = CFG_W'(ss);
        c.sync_end   = CFG_W'(se);
        c.total      = CFG_W'(tot);
        return c;
    endfunction

    // An axis is usable when 1 <= visible <= sync_start < sync_end <= total.
    function automatic logic cfg_legal(input axis_cfg_t c);
        return (c.visible != '0) &&
               (c.visible <= c.sync_start) &&
               (c.sync_start < c.sync_end) &&
               (c.sync_end <= c.total);
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: position counter with wrap flag plus registered blank/sync decodes.
// Latency: decodes are registered alongside the position, so they describe o_pos in the same cycle.
// Backpressure: none; i_ce low holds position and decodes.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int W               = 9,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    input  logic [CFG_W-1:0] i_total,
    input  logic [CFG_W-1:0] i_visible_nxt,
    input  logic [CFG_W-1:0] i_sync_start_nxt,
    input  logic [CFG_W-1:0] i_sync_end_nxt,
    output logic [W-1:0]     o_pos,
    output logic             o_wrap,
    output logic             o_blank,
    output logic             o_blank_nxt,
    output logic             o_sync
);

    logic [W-1:0]     r_pos;
    logic             r_blank;
    logic             r_sync;
    logic [W-1:0]     w_pos_nxt;
    logic [CFG_W-1:0] w_pos_nxt_ext;
    logic             w_wrap;
    logic             w_blank_nxt;
    logic             w_sync_nxt;

    // Wrap is judged against the total currently in force, never the one about to load.
    assign w_wrap = (CFG_W'(r_pos) == (i_total - CFG_W'(1)));

    // Next position: advance on enable, restart after the last pixel/line.
    always_comb begin
        w_pos_nxt = r_pos;
        if (i_ce) begin
            w_pos_nxt = w_wrap ? '0 : r_pos + W'(1);
        end
    end

    // Decodes are taken on the position we are about to show, using the config it will be shown with.
    assign w_pos_nxt_ext = CFG_W'(w_pos_nxt);
    assign w_blank_nxt   = (w_pos_nxt_ext >= i_visible_nxt);
    assign w_sync_nxt    = (w_pos_nxt_ext >= i_sync_start_nxt) && (w_pos_nxt_ext < i_sync_end_nxt);

    // Position and its decodes register together so they never disagree.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos   <= '0;
            r_blank <= 1'b0;
            r_sync  <= SYNC_ACTIVE_LOW;
        end else begin
            r_pos   <= w_pos_nxt;
            r_blank <= w_blank_nxt;
            r_sync  <= w_sync_nxt ^ SYNC_ACTIVE_LOW;
        end
    end

    assign o_pos       = r_pos;
    assign o_wrap      = w_wrap;
    assign o_blank     = r_blank;
    assign o_blank_nxt = w_blank_nxt;
    assign o_sync      = r_sync;

endmodule

// File: rtl/video_timing_generator.sv
// Programmable raster timing: h/v counters, sync/blank/visible flags and strobes; config via shadow registers applied at frame wrap.
// Latency: all outputs registered; cfg_error/pending one clock after write, cfg_applied together with position 0,0.
// Backpressure: none; i_ce gates pixel advance, cfg writes are always accepted or rejected in one clock.
module video_timing_generator
    import video_timing_pkg::*;
#(
    parameter int H_WIDTH          = 9,
    parameter int V_WIDTH          = 9,
    parameter int H_VISIBLE        = H_VISIBLE_DEF,
    parameter int H_SYNC_START     = H_SYNC_START_DEF,
    parameter int H_SYNC_END       = H_SYNC_END_DEF,
    parameter int H_TOTAL          = H_TOTAL_DEF,
    parameter int V_VISIBLE        = V_VISIBLE_DEF,
    parameter int V_SYNC_START     = V_SYNC_START_DEF,
    parameter int V_SYNC_END       = V_SYNC_END_DEF,
    parameter int V_TOTAL          = V_TOTAL_DEF,
    parameter bit HSYNC_ACTIVE_LOW = 1'b1,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ce,
    input  logic               i_cfg_wr,
    input  logic [H_WIDTH-1:0] i_cfg_h_visible,
    input  logic [H_WIDTH-1:0] i_cfg_h_sync_start,
    input  logic [H_WIDTH-1:0] i_cfg_h_sync_end,
    input  logic [H_WIDTH-1:0] i_cfg_h_total,
    input  logic [V_WIDTH-1:0] i_cfg_v_visible,
    input  logic [V_WIDTH-1:0] i_cfg_v_sync_start,
    input  logic [V_WIDTH-1:0] i_cfg_v_sync_end,
    input  logic [V_WIDTH-1:0] i_cfg_v_total,
    output logic [H_WIDTH-1:0] o_hpos,
    output logic [V_WIDTH-1:0] o_vpos,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_hblank,
    output logic               o_vblank,
    output logic               o_visible,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic               o_cfg_pending,
    output logic               o_cfg_applied,
    output logic               o_cfg_error
);

    localparam axis_cfg_t H_RST = make_cfg(H_VISIBLE, H_SYNC_START, H_SYNC_END, H_TOTAL);
    localparam axis_cfg_t V_RST = make_cfg(V_VISIBLE, V_SYNC_START, V_SYNC_END, V_TOTAL);

    axis_cfg_t        r_h_shadow;
    axis_cfg_t        r_v_shadow;
    axis_cfg_t        r_h_active;
    axis_cfg_t        r_v_active;
    logic             r_pending;
    logic             r_cfg_applied;
    logic             r_cfg_error;
    logic             r_line_start;
    logic             r_frame_start;
    logic             r_visible;

    axis_cfg_t        w_h_wr;
    axis_cfg_t        w_v_wr;
    logic             w_wr_legal;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_v_ce;
    logic             w_apply;
    logic             w_h_blank_nxt;
    logic             w_v_blank_nxt;
    logic [CFG_W-1:0] w_h_vis_nxt;
    logic [CFG_W-1:0] w_h_ss_nxt;
    logic [CFG_W-1:0] w_h_se_nxt;
    logic [CFG_W-1:0] w_v_vis_nxt;
    logic [CFG_W-1:0] w_v_ss_nxt;
    logic [CFG_W-1:0] w_v_se_nxt;

    assign w_h_wr = '{visible:    CFG_W'(i_cfg_h_visible),
                      sync_start: CFG_W'(i_cfg_h_sync_start),
                      sync_end:   CFG_W'(i_cfg_h_sync_end),
                      total:      CFG_W'(i_cfg_h_total)};
    assign w_v_wr = '{visible:    CFG_W'(i_cfg_v_visible),
                      sync_start: CFG_W'(i_cfg_v_sync_start),
                      sync_end:   CFG_W'(i_cfg_v_sync_end),
                      total:      CFG_W'(i_cfg_v_total)};

    assign w_wr_legal = cfg_legal(w_h_wr) && cfg_legal(w_v_wr);
    assign w_v_ce     = i_ce & w_h_wrap;
    assign w_apply    = i_ce & w_h_wrap & w_v_wrap & r_pending;

    // Position 0,0 after an apply must already be decoded with the incoming config.
    assign w_h_vis_nxt = w_apply ? r_h_shadow.visible    : r_h_active.visible;
    assign w_h_ss_nxt  = w_apply ? r_h_shadow.sync_start : r_h_active.sync_start;
    assign w_h_se_nxt  = w_apply ? r_h_shadow.sync_end   : r_h_active.sync_end;
    assign w_v_vis_nxt = w_apply ? r_v_shadow.visible    : r_v_active.visible;
    assign w_v_ss_nxt  = w_apply ? r_v_shadow.sync_start : r_v_active.sync_start;
    assign w_v_se_nxt  = w_apply ? r_v_shadow.sync_end   : r_v_active.sync_end;

    video_axis_counter #(
        .W               (H_WIDTH),
        .SYNC_ACTIVE_LOW (HSYNC_ACTIVE_LOW)
    ) u_h_axis (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_ce             (i_ce),
        .i_total          (r_h_active.total),
        .i_visible_nxt    (w_h_vis_nxt),
        .i_sync_start_nxt (w_h_ss_nxt),
        .i_sync_end_nxt   (w_h_se_nxt),
        .o_pos            (o_hpos),
        .o_wrap           (w_h_wrap),
        .o_blank          (o_hblank),
        .o_blank_nxt      (w_h_blank_nxt),
        .o_sync           (o_hsync)
    );

    video_axis_counter #(
        .W               (V_WIDTH),
        .SYNC_ACTIVE_LOW (VSYNC_ACTIVE_LOW)
    ) u_v_axis (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_ce             (w_v_ce),
        .i_total          (r_v_active.total),
        .i_visible_nxt    (w_v_vis_nxt),
        .i_sync_start_nxt (w_v_ss_nxt),
        .i_sync_end_nxt   (w_v_se_nxt),
        .o_pos            (o_vpos),
        .o_wrap           (w_v_wrap),
        .o_blank          (o_vblank),
        .o_blank_nxt      (w_v_blank_nxt),
        .o_sync           (o_vsync)
    );

    // Shadow capture, frame-boundary apply and status pulses; a write landing on an apply queues behind it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_shadow    <= H_RST;
            r_v_shadow    <= V_RST;
            r_h_active    <= H_RST;
            r_v_active    <= V_RST;
            r_pending     <= 1'b0;
            r_cfg_applied <= 1'b0;
            r_cfg_error   <= 1'b0;
        end else begin
            r_cfg_error   <= i_cfg_wr & ~w_wr_legal;
            r_cfg_applied <= w_apply;
            if (w_apply) begin
                r_h_active <= r_h_shadow;
                r_v_active <= r_v_shadow;
            end
            if (i_cfg_wr && w_wr_legal) begin
                r_h_shadow <= w_h_wr;
                r_v_shadow <= w_v_wr;
                r_pending  <= 1'b1;
            end else if (w_apply) begin
                r_pending  <= 1'b0;
            end
        end
    end

    // Position strobes and the combined visible flag move with the pixel enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_line_start  <= 1'b1;
            r_frame_start <= 1'b1;
            r_visible     <= 1'b1;
        end else if (i_ce) begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap & w_v_wrap;
            r_visible     <= ~(w_h_blank_nxt | w_v_blank_nxt);
        end
    end

    assign o_visible     = r_visible;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_cfg_pending = r_pending;
    assign o_cfg_applied = r_cfg_applied;
    assign o_cfg_error   = r_cfg_error;

endmodule

// File: tb/tb_video_timing_generator.sv
// Scoreboard bench for video_timing_generator: driver pushes model expectations, monitor pops and compares.
// Latency: one expectation per clock edge, checked 1 time unit after the edge.
// Backpressure: not applicable.
module tb_video_timing_generator;

    typedef struct { int vis; int ss; int se; int tot; } acfg_t;
    typedef struct {
        int hpos; int vpos;
        bit hsync; bit vsync; bit hblank; bit vblank; bit visible;
        bit ls; bit fs; bit pend; bit app; bit err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ce = 1'b0;
    logic       wr = 1'b0;
    logic [8:0] chv = '0, chs = '0, che = '0, cht = '0;
    logic [8:0] cvv = '0, cvs = '0, cve = '0, cvt = '0;
    logic [8:0] hpos, vpos;
    logic       hsync, vsync, hblank, vblank, visible, line_start, frame_start;
    logic       pending, applied, error;

    video_timing_generator #(
        .H_WIDTH(9), .V_WIDTH(9),
        .H_VISIBLE(10), .H_SYNC_START(12), .H_SYNC_END(16), .H_TOTAL(20),
        .V_VISIBLE(3), .V_SYNC_START(5), .V_SYNC_END(6), .V_TOTAL(9),
        .HSYNC_ACTIVE_LOW(1'b1), .VSYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_cfg_wr(wr),
        .i_cfg_h_visible(chv), .i_cfg_h_sync_start(chs), .i_cfg_h_sync_end(che), .i_cfg_h_total(cht),
        .i_cfg_v_visible(cvv), .i_cfg_v_sync_start(cvs), .i_cfg_v_sync_end(cve), .i_cfg_v_total(cvt),
        .o_hpos(hpos), .o_vpos(vpos), .o_hsync(hsync), .o_vsync(vsync),
        .o_hblank(hblank), .o_vblank(vblank), .o_visible(visible),
        .o_line_start(line_start), .o_frame_start(frame_start),
        .o_cfg_pending(pending), .o_cfg_applied(applied), .o_cfg_error(error)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_fail = 0;
    int    n_push = 0;
    int    n_pop = 0;
    exp_t  exp_q[$];

    // Reference model state: raster position, active/shadow timing, pending flag, last-edge pulses.
    int    m_h, m_v;
    acfg_t ah, av, shh, shv;
    bit    m_pend, m_app, m_err;

    function automatic acfg_t mk(input int vis, input int ss, input int se, input int tot);
        acfg_t c;
        c.vis = vis; c.ss = ss; c.se = se; c.tot = tot;
        return c;
    endfunction

    function automatic bit legal(input acfg_t c);
        return (c.vis >= 1) && (c.vis <= c.ss) && (c.ss < c.se) && (c.se <= c.tot);
    endfunction

    function automatic acfg_t rnd_cfg();
        acfg_t c;
        c.vis = int'($urandom_range(1, 8));
        c.ss  = c.vis + int'($urandom_range(0, 3));
        c.se  = c.ss + int'($urandom_range(1, 3));
        c.tot = c.se + int'($urandom_range(0, 4));
        case ($urandom_range(0, 7))
            0: c.vis = 0;
            1: c.se  = c.ss;
            2: c.tot = c.se - 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_v = 0;
        ah = mk(10, 12, 16, 20); av = mk(3, 5, 6, 9);
        shh = ah; shv = av;
        m_pend = 0; m_app = 0; m_err = 0;
    endtask

    // One clock edge of the raster as described by its rules.
    task automatic model_edge(input bit c, input bit w, input acfg_t nh, input acfg_t nv);
        bit eol, eof, ok;
        eol = (m_h == ah.tot - 1);
        eof = eol && (m_v == av.tot - 1);
        ok  = legal(nh) && legal(nv);
        m_err = w && !ok;
        m_app = c && eof && m_pend;
        if (m_app) begin ah = shh; av = shv; end
        if (w && ok) begin shh = nh; shv = nv; m_pend = 1; end
        else if (m_app) m_pend = 0;
        if (c) begin
            if (eol) begin m_h = 0; m_v = eof ? 0 : m_v + 1; end
            else m_h = m_h + 1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.hpos    = m_h;
        e.vpos    = m_v;
        e.hsync   = !(m_h >= ah.ss && m_h < ah.se);
        e.vsync   = !(m_v >= av.ss && m_v < av.se);
        e.hblank  = (m_h >= ah.vis);
        e.vblank  = (m_v >= av.vis);
        e.visible = !e.hblank && !e.vblank;
        e.ls      = (m_h == 0);
        e.fs      = (m_h == 0) && (m_v == 0);
        e.pend    = m_pend;
        e.app     = m_app;
        e.err     = m_err;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        chk("hpos",        int'(hpos),        e.hpos);
        chk("vpos",        int'(vpos),        e.vpos);
        chk("hsync",       int'(hsync),       int'(e.hsync));
        chk("vsync",       int'(vsync),       int'(e.vsync));
        chk("hblank",      int'(hblank),      int'(e.hblank));
        chk("vblank",      int'(vblank),      int'(e.vblank));
        chk("visible",     int'(visible),     int'(e.visible));
        chk("line_start",  int'(line_start),  int'(e.ls));
        chk("frame_start", int'(frame_start), int'(e.fs));
        chk("cfg_pending", int'(pending),     int'(e.pend));
        chk("cfg_applied", int'(applied),     int'(e.app));
        chk("cfg_error",   int'(error),       int'(e.err));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_hpos"},        int'(hpos),        0);
        chk({tag, "_vpos"},        int'(vpos),        0);
        chk({tag, "_hsync"},       int'(hsync),       1);
        chk({tag, "_vsync"},       int'(vsync),       1);
        chk({tag, "_visible"},     int'(visible),     1);
        chk({tag, "_line_start"},  int'(line_start),  1);
        chk({tag, "_frame_start"}, int'(frame_start), 1);
        chk({tag, "_pending"},     int'(pending),     0);
        chk({tag, "_applied"},     int'(applied),     0);
        chk({tag, "_error"},       int'(error),       0);
    endtask

    // Drive inputs for the coming edge, record the model's answer, then move to 2 units past that edge.
    task automatic step(input bit c, input bit w, input acfg_t nh, input acfg_t nv);
        ce  = c;
        wr  = w;
        chv = 9'(nh.vis); chs = 9'(nh.ss); che = 9'(nh.se); cht = 9'(nh.tot);
        cvv = 9'(nv.vis); cvs = 9'(nv.ss); cve = 9'(nv.se); cvt = 9'(nv.tot);
        if (rst_n) model_edge(c, w, nh, nv);
        else begin m_app = 0; m_err = 0; end
        exp_q.push_back(model_out());
        n_push++;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input bit c);
        step(c, 1'b0, mk(0, 0, 0, 0), mk(0, 0, 0, 0));
    endtask

    // Monitor: one expectation per edge once the driver has queued it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_pop++;
                compare(e);
            end
        end
    end

    // Driver.
    initial begin
        bit hit;
        model_reset();
        #3 rst_n = 1'b0;
        #1 check_reset("rst_init");
        @(posedge clk);
        #2;
        repeat (2) idle(1'b1);
        rst_n = 1'b1;

        // Basic raster, continuous enable.
        repeat (400) idle(1'b1);

        // Enable every other clock.
        for (int i = 0; i < 400; i++) idle(i % 2 == 0);

        // Mid-frame legal write widening the line to 24.
        repeat (50) idle(1'b1);
        step(1'b1, 1'b1, mk(10, 12, 16, 24), mk(3, 5, 6, 9));
        repeat (500) idle(1'b1);

        // Illegal write: sync end beyond total.
        repeat (30) idle(1'b1);
        step(1'b1, 1'b1, mk(10, 12, 25, 20), mk(3, 5, 6, 9));
        repeat (250) idle(1'b1);

        // Config A pending, config B written on the very frame-wrap edge.
        step(1'b1, 1'b1, mk(10, 12, 16, 22), mk(3, 5, 6, 9));
        hit = 0;
        for (int k = 0; k < 1000; k++) begin
            if (m_h == ah.tot - 1 && m_v == av.tot - 1) begin hit = 1; break; end
            idle(1'b1);
        end
        chk("wrap_reached", int'(hit), 1);
        step(1'b1, 1'b1, mk(8, 9, 11, 14), mk(2, 3, 4, 6));
        repeat (500) idle(1'b1);

        // Asynchronous reset in the middle of a line of the programmed timing.
        hit = 0;
        for (int k = 0; k < 100; k++) begin
            if (m_h == 5) begin hit = 1; break; end
            idle(1'b1);
        end
        chk("midline_reached", int'(hit), 1);
        rst_n = 1'b0;
        #1 check_reset("rst_midline");
        model_reset();
        @(posedge clk);
        #2;
        repeat (2) idle(1'b1);
        rst_n = 1'b1;
        repeat (300) idle(1'b1);

        // Random enable and random (sometimes illegal) writes.
        for (int i = 0; i < 3000; i++) begin
            bit    c, w;
            acfg_t rh, rv;
            c  = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 39) == 0);
            rh = rnd_cfg();
            rv = rnd_cfg();
            step(c, w, rh, rv);
        end

        chk("scoreboard_drained", n_pop, n_push);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_generator.md
# video_timing_generator

Runtime-programmable raster timing generator: the successor of the fixed-parameter video sync generator. It produces horizontal/vertical counters and the sync, blank, visible and line/frame-start strobes. Active timing can be reprogrammed through a shadow-register port, and new values take effect only at a frame boundary. Sits between the pixel clock domain and the pattern/framebuffer pipelines of the VGA projects; a pixel-clock enable allows running from a faster system clock.

## Interface
- H_WIDTH, 9: width of horizontal counter and config fields
- V_WIDTH, 9: width of vertical counter and config fields
- H_VISIBLE, 256: reset-default visible pixels per line
- H_SYNC_START, 280: reset-default first hsync pixel
- H_SYNC_END, 305: reset-default first pixel after hsync
- H_TOTAL, 341: reset-default pixels per line
- V_VISIBLE, 240 / V_SYNC_START, 243 / V_SYNC_END, 246 / V_TOTAL, 262: vertical equivalents, in lines
- HSYNC_ACTIVE_LOW, 1 / VSYNC_ACTIVE_LOW, 1: sync output polarity
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_ce  in  1  pixel enable; counters advance only when high
- i_cfg_wr  in  1  single-cycle write strobe for all eight cfg fields
- i_cfg_h_visible, i_cfg_h_sync_start, i_cfg_h_sync_end, i_cfg_h_total  in  H_WIDTH each  horizontal config
- i_cfg_v_visible, i_cfg_v_sync_start, i_cfg_v_sync_end, i_cfg_v_total  in  V_WIDTH each  vertical config
- o_hpos  out  H_WIDTH  current pixel; o_vpos  out  V_WIDTH  current line
- o_hsync, o_vsync  out  1  sync, polarity per parameter
- o_hblank, o_vblank, o_visible  out  1  blanking and active-area flags
- o_line_start, o_frame_start  out  1  position strobes
- o_cfg_pending  out  1  shadow holds an unapplied config
- o_cfg_applied, o_cfg_error  out  1  single-clock status pulses

## Operation
- Counters: h counts 0..h_total-1 on each i_ce. On h wrap, v increments and wraps after v_total-1.
- Decodes use the active config: hblank = h ≥ h_visible; hsync active for h in [h_sync_start, h_sync_end); same rules apply vertically. visible = !hblank && !vblank. line_start = (h==0); frame_start = (h==0 && v==0).
- Cfg legality per axis: 1 ≤ visible ≤ sync_start < sync_end ≤ total.
- i_cfg_wr with a legal config: all fields load into the shadow and pending is set.
- i_cfg_wr with an illegal config: o_cfg_error pulses, and shadow and pending are unchanged.
- Frame wrap (i_ce, h==h_total-1, v==v_total-1) with pending set: active ← shadow, pending cleared, o_cfg_applied pulses. Counters go to 0 and use the new config.
- Write coinciding with an apply: the pre-write shadow is applied. The new write is captured and pending stays 1 for the next frame.
- Reset: counters = 0, active config = parameters, pending = 0, pulses = 0. Decodes follow from position 0: o_visible=1, o_line_start=1, o_frame_start=1, syncs inactive.

## Timing
- All outputs are registered and mutually consistent: every flag describes the position shown on o_hpos/o_vpos in the same cycle.
- Position and flags update on the i_clk edge where i_ce=1, and hold while i_ce=0. Strobes therefore last one pixel period, not one clock.
- o_cfg_error appears on the clock after i_cfg_wr. o_cfg_applied appears in the same cycle that o_hpos/o_vpos show 0,0.
- o_cfg_pending rises on the clock after a legal i_cfg_wr.
- Reset is asynchronous: outputs take their reset values immediately, and release is synchronous to i_clk.

## Structure
- Package video_timing_pkg holds:
  - parametrised axis-config struct typedef (visible, sync_start, sync_end, total)
  - default constants
  - cfg_legal() function
- Sub-module video_axis_counter is instantiated once per axis. It contains the enable, the counter, the wrap flag and the blank/sync decodes.
- The top level holds the shadow/active registers and the apply logic.

## Test plan
Small timing for all tests: H 10/12/16/20, V 3/5/6/9, i_ce=1 unless stated.
- Basic raster: hsync low for h 12..15, hblank for h ≥ 10, vsync low for line 5 only, frame_start every 180 clocks.
- i_ce high every other clock: hpos holds on ce=0 cycles; frame period 360 clocks; line_start high for 2 clocks.
- Mid-frame write with h_total=24: pending=1 the next clock; lines stay 20 until frame wrap; applied pulses with hpos=0,vpos=0; following lines 24 pixels.
- Illegal write (h_sync_end=25 > h_total=20): cfg_error one clock; pending and timing unchanged.
- Pending config A plus a write of B in the frame-wrap cycle: A becomes active, B pending, and B is applied at the next wrap.
- i_rst_n low mid-line after an applied config: hpos=0 and vpos=0 immediately, parameter timing restored, pending=0.
